// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
//   state_e     : IDLE (waiting for a word) / SHIFT (a frame is on the wire)
//   cnt_width() : bit-counter width for an N-bit word
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of the bit index counter. $clog2(2) is already 1, so a two-bit
  // word still gets a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter.
// Accepts an N-bit word over a valid/ready handshake and emits it one bit per
// consumed cycle on a serial valid/ready stream, MSB or LSB first per word.
// Ports:
//   clk          : clock, all state changes on the rising edge
//   reset_n      : asynchronous active-low reset
//   in_data      : parallel word to transmit
//   in_valid     : in_data is valid
//   in_ready     : a word is accepted on this cycle's edge if in_valid is high
//   lsb_first    : bit order captured with the word (1 = LSB first)
//   serial_out   : current serial bit
//   serial_valid : serial_out holds a valid bit
//   shift_en     : downstream consumes the current bit this cycle
//   frame_first  : current bit is bit 0 of the frame
//   frame_last   : current bit is the last bit of the frame
//   busy         : a frame is in progress
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         lsb_first,
  output logic         serial_out,
  output logic         serial_valid,
  input  logic         shift_en,
  output logic         frame_first,
  output logic         frame_last,
  output logic         busy
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsb_q, lsb_d;

  logic load;
  logic consume;

  // Output flags are derived straight from state and counter so that an
  // asynchronous reset clears them immediately, not at the next edge.
  assign serial_valid = (state_q == SHIFT);
  assign busy         = (state_q == SHIFT);
  assign serial_out   = serial_valid & (lsb_q ? shreg_q[0] : shreg_q[N-1]);
  assign frame_first  = serial_valid & (cnt_q == '0);
  assign frame_last   = serial_valid & (cnt_q == LAST_IDX);

  // Ready also opens while the last bit is being consumed, which is what lets
  // consecutive words go out with no gap. Held low while in reset.
  assign in_ready = reset_n & ((state_q == IDLE) | (frame_last & shift_en));

  assign load    = in_valid & in_ready;
  assign consume = serial_valid & shift_en;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;

    if (load) begin
      // A load takes priority: it also covers the last-bit consume edge.
      state_d = SHIFT;
      shreg_d = in_data;
      lsb_d   = lsb_first;
      cnt_d   = '0;
    end else if (consume) begin
      shreg_d = lsb_q ? {1'b0, shreg_q[N-1:1]} : {shreg_q[N-2:0], 1'b0};
      if (frame_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int N = 8;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         lsb_first;
  logic         serial_out;
  logic         serial_valid;
  logic         shift_en;
  logic         frame_first;
  logic         frame_last;
  logic         busy;

  piso_serializer #(.N(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .lsb_first    (lsb_first),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .shift_en     (shift_en),
    .frame_first  (frame_first),
    .frame_last   (frame_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;   // cycles since the last accepted word (cycle 1 = first bit)
  int   last_cyc = 0;   // cycle at which frame_last was last seen

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard: expected bits are queued when a word is accepted, the head is
  // compared each cycle and popped when downstream consumes it.
  always @(negedge clk) begin
    if (reset_n) begin
      logic exp_valid;
      logic exp_ready;
      exp_t e;
      cyc++;
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() == 0) || (q.size() == 1 && shift_en);
      check("serial_valid", 32'(serial_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_valid));
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      if (frame_last) last_cyc = cyc;
      if (exp_valid) begin
        e = q[0];
        check("serial_out", 32'(serial_out), 32'(e.b));
        check("frame_first", 32'(frame_first), 32'(e.f));
        check("frame_last", 32'(frame_last), 32'(e.l));
        if (shift_en) void'(q.pop_front());
      end else begin
        check("idle_serial_out", 32'(serial_out), 32'd0);
        check("idle_frame_last", 32'(frame_last), 32'd0);
      end
      if (in_valid && exp_ready) begin
        for (int i = 0; i < N; i++) begin
          int idx;
          idx = lsb_first ? i : N - 1 - i;
          e.b = in_data[idx];
          e.f = (i == 0);
          e.l = (i == N - 1);
          q.push_back(e);
        end
        cyc = 0;
        $display("load data=%02h lsb_first=%0d", in_data, lsb_first);
      end
    end
  end

  // Drive a word and hold it until accepted; returns just after the load edge.
  task automatic send_word(input logic [N-1:0] d, input logic lsb);
    logic acc;
    acc = 1'b0;
    in_data   = d;
    lsb_first = lsb;
    in_valid  = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) check("idle_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    lsb_first = 1'b0;
    shift_en  = 1'b1;

    // Reset state.
    #12;
    check("rst_serial_valid", 32'(serial_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_serial_out", 32'(serial_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_frame_first", 32'(frame_first), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // MSB-first 0xC1.
    send_word(8'hC1, 1'b0);
    wait_idle();
    check("msb_last_cycle", 32'(last_cyc), 32'd8);

    // LSB-first 0xC1.
    send_word(8'hC1, 1'b1);
    wait_idle();
    check("lsb_last_cycle", 32'(last_cyc), 32'd8);

    // Back-to-back: 0x0F is accepted on the cycle-8 edge.
    send_word(8'hC1, 1'b0);
    send_word(8'h0F, 1'b0);
    check("b2b_accept_cycle", 32'(cyc), 32'd0);
    wait_idle();
    check("b2b_last_cycle", 32'(last_cyc), 32'd8);

    // Stall while bit index 3 is presented.
    send_word(8'hC1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    shift_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    shift_en = 1'b1;
    wait_idle();
    check("stall_last_cycle", 32'(last_cyc), 32'd11);

    // Ignored load during bit 2.
    send_word(8'hC1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    check("ignored_last_cycle", 32'(last_cyc), 32'd8);

    // Asynchronous reset mid-frame at bit 5.
    send_word(8'hC1, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_serial_valid", 32'(serial_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_serial_out", 32'(serial_out), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("arst_release_ready", 32'(in_ready), 32'd1);
    send_word(8'hFF, 1'b0);
    wait_idle();
    check("arst_last_cycle", 32'(last_cyc), 32'd8);

    // Random words with random order and random back-pressure.
    for (int k = 0; k < 6; k++) begin
      send_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 12; c++) begin
        shift_en = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      shift_en = 1'b1;
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter.
- Accepts an N-bit word over a valid/ready handshake and emits it one bit per consumed cycle on a serial valid/ready stream.
- Feeds serial-input shift registers and deserializers in the datapath.
- Supports MSB-first or LSB-first order per word, downstream stall, and back-to-back words with zero gap cycles.

Parameters:
- N, 8, word width in bits; legal range N >= 2.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  N  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- lsb_first  input  1  bit order, sampled with the word at load: 1 = LSB first, 0 = MSB first.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out holds a valid bit.
- shift_en  input  1  downstream consumes the current bit this cycle (serial ready).
- frame_first  output  1  current bit is bit 0 of the frame.
- frame_last  output  1  current bit is the last (Nth) bit of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. While reset_n is low, state = IDLE and the output values are:
  - serial_out = 0, serial_valid = 0, frame_first = 0, frame_last = 0, busy = 0.
  - shift register = 0, bit counter = 0.
  - in_ready = 0 while reset_n is low; 1 in IDLE after release.
- State machine: IDLE and SHIFT.
- Load:
  - A word loads on any rising edge where in_valid && in_ready.
  - in_data and lsb_first are captured together.
  - State goes to SHIFT and the bit counter clears to 0.
- Latency: the first bit appears on serial_out with serial_valid = 1 in the cycle after the load edge. frame_first = 1 in that cycle only.
- Bit consumption:
  - A bit is consumed on each edge where serial_valid && shift_en. The counter then increments and the register shifts.
  - MSB-first: serial_out = reg[N-1], and the register shifts left with zero fill.
  - LSB-first: serial_out = reg[0], and the register shifts right with zero fill.
- Stall: with shift_en = 0, serial_out, serial_valid, frame_first, frame_last and the counter all hold. There is no timeout.
- frame_last = 1 exactly while the counter = N-1 and serial_valid = 1.
- in_ready (combinational) = (state == IDLE) || (frame_last && shift_en). It is 0 during bits 0..N-2 and during a stalled last bit.
- End of frame, when the last bit is consumed:
  - If in_valid is high in the same cycle, the next word loads on that edge. Its bit 0 follows in the next cycle with no gap; frame_first = 1, and busy and serial_valid stay 1.
  - Otherwise the block returns to IDLE: serial_valid = 0, serial_out = 0, busy = 0.
- busy = (state == SHIFT).
- in_valid while in_ready = 0: the word is ignored and not latched. The source must hold in_data and in_valid until accepted.
- lsb_first changes mid-frame have no effect on the current frame.
- Reset mid-frame: the frame is aborted immediately with no partial completion. After release the block is in IDLE with in_ready = 1.
- Counter width: $clog2(N). No wrap occurs because it clears at every load.

Decomposition:
- Shared package: state enum type (IDLE, SHIFT) and a CNT_W = $clog2(N) helper function/constant.
- No sub-module: the counter and shifter are single always blocks plus combinational ready/flag logic.

Test Plan:
- MSB-first, 0xC1, shift_en tied 1, in_valid one cycle:
  - serial_out = 1,1,0,0,0,0,0,1 on cycles 1-8 after the load edge.
  - frame_first at cycle 1, frame_last at cycle 8, in_ready 0 on cycles 1-7.
  - serial_valid 0 at cycle 9.
- LSB-first, 0xC1 -> serial_out = 1,0,0,0,0,0,1,1; flags as in the previous test.
- Back-to-back: 0xC1 then 0x0F, MSB-first, in_valid held -> 16 contiguous serial_valid cycles.
  - Bits 1,1,0,0,0,0,0,1,0,0,0,0,1,1,1,1.
  - frame_first at cycles 1 and 9, frame_last at 8 and 16.
  - 0x0F is accepted at the cycle-8 edge.
- Stall: 0xC1 MSB-first, shift_en = 0 for 3 cycles while bit index 3 is presented -> serial_out holds 0 with serial_valid = 1; frame_last appears at cycle 11, with no lost or duplicated bits.
- Ignored load: while bit 2 of 0xC1 is being sent, drive in_valid with 0xFF for 1 cycle -> not latched; frame completes as 0xC1 and the block returns to IDLE.
- Reset mid-frame: assert reset_n = 0 asynchronously at bit 5 -> serial_valid, busy and serial_out go 0 without waiting for an edge. After release, in_ready = 1; a load of 0xFF yields 8 ones with correct frame_first/frame_last.
